// File: rtl/pio_pkg.sv
// Shared register offsets and parameter encodings for the input PIO slave.
package pio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [ADDR_W-1:0] PIO_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] PIO_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] PIO_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] PIO_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    localparam int unsigned IRQ_NONE  = 0;
    localparam int unsigned IRQ_EDGE  = 1;
    localparam int unsigned IRQ_LEVEL = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// Debounce filter for the synchronised inputs: one stability window shared
// by all bits; DEBOUNCE_CYCLES = 0 passes the input straight through.
module pio_in_debounce
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] filt
);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign filt = s2;
        end else begin : g_filter
            logic [WIDTH-1:0] filt_q;
            logic [WIDTH-1:0] last;
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_inc;
            logic [CNT_W-1:0] cnt_next;
            logic             adopt;

            // Count consecutive edges on which s2 held the same value; a change restarts at 1.
            always_comb begin
                cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
                cnt_next = (s2 != last) ? CNT_W'(1) : cnt_inc;
                adopt    = (s2 != filt_q) && (cnt_next >= CNT_W'(DEBOUNCE_CYCLES));
            end

            // Window counter and filtered value; filt adopts s2 once the window is met.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= '0;
                    last   <= '0;
                    cnt    <= '0;
                end else begin
                    last <= s2;
                    if (s2 == filt_q) begin
                        cnt <= '0;
                    end else if (adopt) begin
                        filt_q <= s2;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
            end

            assign filt = filt_q;
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO slave: synchroniser, optional debounce, per-bit edge
// capture with write-1-to-clear, and a maskable edge or level interrupt.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] w1c_bits;
    logic             wr_en;
    logic             irq_next;
    logic [BUS_W-1:0] rd_next;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    pio_in_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .s2      (s2),
        .filt    (filt)
    );

    // Per-bit edge detect on the filtered value, W1C mask and interrupt source selection.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edges = ~filt & filt_d;
            EDGE_ANY:     edges = filt ^ filt_d;
            default:      edges = filt & ~filt_d;
        endcase

        w1c_bits = '0;
        if (wr_en && (address == PIO_EDGECAP)) begin
            w1c_bits = writedata[WIDTH-1:0];
        end

        // Fresh edges feed the edge irq directly so it tracks EDGECAPTURE; clears land one edge later.
        case (IRQ_TYPE)
            IRQ_EDGE:  irq_next = |((edge_cap | edges) & irq_mask);
            IRQ_LEVEL: irq_next = |(filt_d & irq_mask);
            default:   irq_next = 1'b0;
        endcase
    end

    // Delayed filt, IRQMASK and EDGECAPTURE; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d   <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            filt_d   <= filt;
            edge_cap <= (edge_cap & ~w1c_bits) | edges;
            if (wr_en && (address == PIO_IRQMASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux; unused upper bits and the reserved offset read as zero.
    always_comb begin
        case (address)
            PIO_DATA:    rd_next = BUS_W'(filt);
            PIO_IRQMASK: rd_next = BUS_W'(irq_mask);
            PIO_EDGECAP: rd_next = BUS_W'(edge_cap);
            default:     rd_next = '0;
        endcase
    end

    // Registered read data and interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_next;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboarded bench for pio_in_edge_irq: three instances cover the plain
// rising/edge-irq build, a debounced build and an any-edge/level-irq build.
module tb_pio_in_edge_irq;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  cs;
    logic [15:0] pin0, pin1, pin2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(16), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(pin0),
        .readdata(rd0), .irq(irq0));

    pio_in_edge_irq #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(pin1),
        .readdata(rd1), .irq(irq1));

    pio_in_edge_irq #(.WIDTH(16), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_TYPE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(pin2),
        .readdata(rd2), .irq(irq2));

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int inst);
        case (inst)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic irq_of(input int inst);
        case (inst)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    // Advance n active edges and sample 1 time unit later.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected value enters the scoreboard when the read address is driven.
    task automatic expect_rd(input int inst, input logic [1:0] addr, input logic [31:0] exp,
                             input string tag);
        address = addr;
        exp_q.push_back(exp);
        tick();
        check_eq(tag, rdata_of(inst), exp_q.pop_front());
    endtask

    task automatic sample_rd(input int inst, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        check_eq(tag, rdata_of(inst), exp_q.pop_front());
    endtask

    task automatic sample_irq(input int inst, input logic exp, input string tag);
        exp_q.push_back(32'(exp));
        check_eq(tag, 32'(irq_of(inst)), exp_q.pop_front());
    endtask

    task automatic wr(input int inst, input logic [1:0] addr, input logic [31:0] data);
        cs        = 3'b000;
        cs[inst]  = 1'b1;
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        tick();
        cs      = 3'b000;
        write_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = PIO_DATA;
        write_n   = 1'b1;
        writedata = '0;
        cs        = 3'b000;
        pin0      = '0;
        pin1      = '0;
        pin2      = '0;
        tick(2);
        reset_n = 1'b1;
        tick();

        // Reset state
        sample_rd(0, 32'h0, "rst_rd0");
        sample_rd(1, 32'h0, "rst_rd1");
        sample_irq(0, 1'b0, "rst_irq0");
        sample_irq(2, 1'b0, "rst_irq2");

        // Basic capture: DATA and EDGECAPTURE at edge 2
        address = PIO_DATA;
        pin0 = 16'h00A5;
        tick(2);
        sample_rd(0, 32'h0, "t1_data_e1");
        tick();
        sample_rd(0, 32'h0000_00A5, "t1_data_e2");
        expect_rd(0, PIO_EDGECAP, 32'h0000_00A5, "t1_edgecap");
        expect_rd(0, PIO_RSVD, 32'h0, "t1_reserved");
        wr(0, PIO_DATA, 32'hFFFF_FFFF);
        expect_rd(0, PIO_DATA, 32'h0000_00A5, "t1_data_ro");
        sample_irq(0, 1'b0, "t1_irq_unmasked");

        // Edge irq, masked to bit0, then W1C
        wr(0, PIO_EDGECAP, 32'hFFFF_FFFF);
        expect_rd(0, PIO_EDGECAP, 32'h0, "t3_cap_cleared");
        wr(0, PIO_IRQMASK, 32'h0000_0001);
        expect_rd(0, PIO_IRQMASK, 32'h0000_0001, "t3_mask");
        pin0 = 16'h00A4;
        tick(4);
        sample_irq(0, 1'b0, "t3_irq_fall");
        pin0 = 16'h00A5;
        tick(2);
        sample_irq(0, 1'b0, "t3_irq_e1");
        tick();
        sample_irq(0, 1'b1, "t3_irq_e2");
        expect_rd(0, PIO_EDGECAP, 32'h0000_0001, "t3_cap_bit0");
        wr(0, PIO_EDGECAP, 32'h0000_0001);
        sample_irq(0, 1'b1, "t3_irq_at_clear");
        tick();
        sample_irq(0, 1'b0, "t3_irq_after_clear");
        sample_rd(0, 32'h0, "t3_cap_after_clear");

        // Set wins over a simultaneous W1C on bit3
        pin0 = 16'h00AD;
        tick(3);
        expect_rd(0, PIO_EDGECAP, 32'h0000_0008, "t4_cap_bit3");
        pin0 = 16'h00A5;
        tick(3);
        pin0 = 16'h00AD;
        tick(2);
        wr(0, PIO_EDGECAP, 32'h0000_0008);
        expect_rd(0, PIO_EDGECAP, 32'h0000_0008, "t4_set_wins");
        wr(0, PIO_EDGECAP, 32'h0000_0008);
        expect_rd(0, PIO_EDGECAP, 32'h0, "t4_plain_clear");

        // Debounce N=4: short glitch rejected, long pulse captured once
        address = PIO_DATA;
        pin1 = 16'h0001;
        tick(2);
        pin1 = 16'h0000;
        tick(12);
        expect_rd(1, PIO_DATA, 32'h0, "t2_glitch_data");
        expect_rd(1, PIO_EDGECAP, 32'h0, "t2_glitch_cap");
        address = PIO_DATA;
        pin1 = 16'h0001;
        tick(6);
        sample_rd(1, 32'h0, "t2_data_e5");
        tick();
        sample_rd(1, 32'h0000_0001, "t2_data_e6");
        tick();
        pin1 = 16'h0000;
        tick(12);
        expect_rd(1, PIO_EDGECAP, 32'h0000_0001, "t2_one_rise");
        expect_rd(1, PIO_DATA, 32'h0, "t2_data_back");
        sample_irq(1, 1'b0, "t2_irq_unmasked");

        // Any-edge capture and level irq
        pin2 = 16'h0002;
        tick(3);
        expect_rd(2, PIO_EDGECAP, 32'h0000_0002, "t5_rise_cap");
        wr(2, PIO_EDGECAP, 32'hFFFF_FFFF);
        pin2 = 16'h0000;
        tick(3);
        expect_rd(2, PIO_EDGECAP, 32'h0000_0002, "t5_fall_cap");
        wr(2, PIO_IRQMASK, 32'h0000_0002);
        sample_irq(2, 1'b0, "t5_irq_low");
        pin2 = 16'h0002;
        tick(3);
        sample_irq(2, 1'b0, "t5_irq_e2");
        tick();
        sample_irq(2, 1'b1, "t5_irq_e3");
        pin2 = 16'h0000;
        tick(3);
        sample_irq(2, 1'b1, "t5_irq_hold");
        tick();
        sample_irq(2, 1'b0, "t5_irq_drop");

        // Upper mask bits ignored, then reset mid-debounce window
        wr(1, PIO_IRQMASK, 32'hFFFF_FFFF);
        expect_rd(1, PIO_IRQMASK, 32'h0000_FFFF, "t6_mask_width");
        pin1 = 16'hFFFF;
        tick(3);
        reset_n = 1'b0;
        #1;
        sample_rd(1, 32'h0, "t6_rd_in_reset");
        sample_irq(1, 1'b0, "t6_irq_in_reset");
        pin0 = '0;
        pin1 = '0;
        pin2 = '0;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        expect_rd(1, PIO_DATA, 32'h0, "t6_data");
        expect_rd(1, PIO_IRQMASK, 32'h0, "t6_mask");
        expect_rd(1, PIO_EDGECAP, 32'h0, "t6_cap");
        expect_rd(0, PIO_EDGECAP, 32'h0, "t6_cap_u0");
        sample_irq(1, 1'b0, "t6_irq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
